// File: rtl/arb_mux_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : arb_mux_pkg                                               |
// | Purpose  : Shared constants for the arbitrated channel multiplexer:   |
// |            operating-mode encodings and the legal CHANNELS range.    |
// | Ports    : none (package)                                            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package arb_mux_pkg;

  localparam int MODE_FIXED   = 0;  // channel chosen directly by sel
  localparam int MODE_RR      = 1;  // round-robin among requesting channels

  localparam int CHANNELS_MIN = 2;
  localparam int CHANNELS_MAX = 16;

endpackage : arb_mux_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_pick                                                   |
// | Purpose  : Combinational round-robin search. Finds the first set bit |
// |            of req starting at index ptr and scanning upward, with    |
// |            wrap from CHANNELS-1 back to 0.                           |
// | Ports    : req       [CHANNELS-1:0] in  - request vector             |
// |            ptr       [SEL_W-1:0]    in  - scan start (< CHANNELS)    |
// |            gnt_valid                out - some request found         |
// |            gnt_idx   [SEL_W-1:0]    out - index of chosen request    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module rr_pick #(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic                gnt_valid,
  output logic [SEL_W-1:0]    gnt_idx
);

  // One spare bit so ptr + offset cannot overflow before the wrap fix-up.
  logic [SEL_W:0] pos;

  // The loop walks offsets from farthest to nearest; the last hit written
  // therefore belongs to the requester closest to ptr in scan order.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    pos       = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (SEL_W + 1)'(k);
      if (pos >= (SEL_W + 1)'(CHANNELS)) begin
        pos = pos - (SEL_W + 1)'(CHANNELS);
      end
      if (req[pos[SEL_W-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = pos[SEL_W-1:0];
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/arb_mux_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : arb_mux_param                                             |
// | Purpose  : N-to-1 channel multiplexer with a one-word registered     |
// |            output stage. Channel choice is either fixed (sel) or     |
// |            round-robin over the requesting channels.                 |
// | Ports    : clk, rst (async, active-high)                             |
// |            in_data  [CHANNELS*DATA_LENGTH-1:0] in  - flattened data  |
// |            in_valid [CHANNELS-1:0]             in  - requests        |
// |            in_ready [CHANNELS-1:0]             out - one-hot accept  |
// |            sel      [SEL_W-1:0]                in  - fixed-mode pick |
// |            out_data [DATA_LENGTH-1:0]          out - held word       |
// |            out_valid                           out - word pending    |
// |            out_ready                           in  - downstream take |
// |            out_chan [SEL_W-1:0]                out - source channel  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module arb_mux_param
  import arb_mux_pkg::*;
#(
  parameter  int DATA_LENGTH = 32,
  parameter  int CHANNELS    = 4,
  parameter  int MODE        = MODE_RR,
  localparam int SEL_W       = $clog2(CHANNELS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CHANNELS*DATA_LENGTH-1:0] in_data,
  input  logic [CHANNELS-1:0]             in_valid,
  output logic [CHANNELS-1:0]             in_ready,
  input  logic [SEL_W-1:0]                sel,
  output logic [DATA_LENGTH-1:0]          out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [SEL_W-1:0]                out_chan
);

  // sel can address up to 2**SEL_W slots; decoding over that full span and
  // then keeping only the real channels makes an out-of-range sel grant
  // nothing without a separate range compare.
  localparam int SPAN = 1 << SEL_W;

  logic [DATA_LENGTH-1:0] chan_data [CHANNELS];

  logic                   out_valid_q, out_valid_d;
  logic [DATA_LENGTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0]       out_chan_q,  out_chan_d;
  logic [SEL_W-1:0]       ptr_q,       ptr_d;

  logic                   can_load;
  logic                   rr_valid;
  logic [SEL_W-1:0]       rr_idx;
  logic                   grant_valid;
  logic [SEL_W-1:0]       grant_idx;
  logic [SPAN-1:0]        grant_onehot;
  logic                   in_xfer;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
    assign chan_data[i] = in_data[i*DATA_LENGTH +: DATA_LENGTH];
  end

  rr_pick #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_rr_pick (
    .req       (in_valid),
    .ptr       (ptr_q),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  // Grant side. In fixed mode the grant does not wait for in_valid, so the
  // upstream may see in_ready before it raises its request.
  always_comb begin
    can_load = ~out_valid_q | out_ready;
    if (MODE == MODE_FIXED) begin
      grant_valid = 1'b1;
      grant_idx   = sel;
    end else begin
      grant_valid = rr_valid;
      grant_idx   = rr_idx;
    end
    grant_onehot = SPAN'(1) << grant_idx;
    in_ready     = '0;
    if (!rst && can_load && grant_valid) begin
      in_ready = grant_onehot[CHANNELS-1:0];
    end
    in_xfer = |(in_ready & in_valid);
  end

  // Output stage and round-robin pointer next state. A new load takes
  // priority over a drain, giving back-to-back words with no bubble.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (in_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = chan_data[grant_idx];
      out_chan_d  = grant_idx;
      if (MODE == MODE_RR) begin
        ptr_d = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + SEL_W'(1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule : arb_mux_param
`default_nettype wire

// File: doc/arb_mux_param.md
ARB_MUX_PARAM -- requirements
Module: arb_mux_param

Interface
REQ-001 SHALL have parameter DATA_LENGTH, default 32, width in bits of each data channel.
REQ-002 SHALL have parameter CHANNELS, default 4, number of input channels, legal range 2..16.
REQ-003 SHALL have parameter MODE, default 1; 0 = fixed select by sel, 1 = round-robin arbitration.
REQ-004 SHALL derive localparam SEL_W = $clog2(CHANNELS).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 in_data  input  CHANNELS*DATA_LENGTH  flattened channel data; channel i at bits [i*DATA_LENGTH +: DATA_LENGTH].
REQ-008 in_valid  input  CHANNELS  per-channel request.
REQ-009 in_ready  output  CHANNELS  per-channel accept; at most one bit high per cycle.
REQ-010 sel  input  SEL_W  channel selection, used only when MODE=0.
REQ-011 out_data  output  DATA_LENGTH  registered selected data.
REQ-012 out_valid  output  1  out_data holds an unconsumed word.
REQ-013 out_ready  input  1  downstream accepts out_data.
REQ-014 out_chan  output  SEL_W  channel index of the word in out_data.

Function
REQ-015 Transfer on input side SHALL occur on a cycle where in_valid[i] & in_ready[i]; on output side where out_valid & out_ready.
REQ-016 Output register SHALL be able to load when it is empty (out_valid=0) or is draining in the same cycle (out_valid & out_ready).
REQ-017 When able to load, MODE=0 SHALL raise in_ready[sel] only if sel < CHANNELS; sel >= CHANNELS SHALL grant nothing.
REQ-018 When able to load, MODE=1 SHALL raise in_ready for the first channel with in_valid=1 scanning from pointer ptr upward, wrapping CHANNELS-1 -> 0.
REQ-019 in_ready SHALL be asserted independent of in_valid only in MODE=0; in MODE=1 in_ready[i] SHALL imply in_valid[i].
REQ-020 On an input transfer, out_data, out_chan SHALL load the granted channel data and index, and out_valid SHALL be 1 next cycle (latency 1 cycle).
REQ-021 On output transfer without simultaneous input transfer, out_valid SHALL clear next cycle; out_data, out_chan SHALL hold.
REQ-022 Simultaneous output and input transfer SHALL replace the word with no bubble (sustained 1 word/cycle).
REQ-023 While out_valid=1 and out_ready=0, out_data, out_chan, out_valid SHALL hold stable and all in_ready SHALL be 0.
REQ-024 ptr (SEL_W bits) SHALL update only on an input transfer in MODE=1, to granted index + 1, wrapping to 0 after CHANNELS-1.
REQ-025 No request pending SHALL leave ptr unchanged and grant nothing.
REQ-026 Changing sel while out_valid=1 SHALL not alter the held word.

Reset
REQ-027 Asserting rst SHALL immediately force out_valid=0, out_data=0, out_chan=0, ptr=0, regardless of clk.
REQ-028 in_ready SHALL be 0 while rst is high; a word held at reset SHALL be discarded.
REQ-029 First grant after rst release SHALL occur on the first rising edge with rst low.

Structure
REQ-030 Shared package arb_mux_pkg SHALL hold MODE_FIXED=0, MODE_RR=1 and the CHANNELS legal bounds.
REQ-031 Round-robin search SHALL be a combinational sub-module rr_pick (inputs req, ptr; outputs gnt_valid, gnt_idx), instantiated once.
REQ-032 Output register and ptr SHALL be the only sequential state.

Verification
REQ-033 MODE=1, CHANNELS=4, in_valid=4'b1111 held, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles, out_valid=1 throughout.
REQ-034 MODE=1, in_valid=4'b1010, ptr=0, out_ready=1 -> grants 1,3,1,3; channels 0,2 never granted.
REQ-035 MODE=0, sel=2, in_data ch2=32'hDEADBEEF, in_valid[2]=1 -> next cycle out_data=32'hDEADBEEF, out_chan=2; ch0 data ignored.
REQ-036 out_ready=0 for 5 cycles after load of 32'h12345678 -> out_data stable, in_ready=0 all 5 cycles; out_ready=1 -> transfer, next grant same cycle.
REQ-037 rst asserted mid-stream between clock edges with out_valid=1 -> out_valid=0 before next edge; after release, ptr=0 so channel 0 granted first.
REQ-038 MODE=0, CHANNELS=3, sel=3 -> in_ready=0 all channels, out_valid stays 0.
